// File: rtl/alu_ctrl_if.sv
// Bus bundle between the sequencer, program memory and the 8-bit ALU.
// The master side is the sequencer; the slave side is memory plus ALU.
interface alu_ctrl_if;
  logic [2:0] opcode;
  logic [7:0] accum;
  logic [7:0] data;
  logic [7:0] alu_out;
  logic       zero;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] mem_rdata;
  logic       mem_wr;
  logic [7:0] mem_wdata;

  modport master (
    output opcode, accum, data, mem_addr, mem_rd, mem_wr, mem_wdata,
    input  alu_out, zero, mem_rdata
  );

  modport slave (
    input  opcode, accum, data, mem_addr, mem_rd, mem_wr, mem_wdata,
    output alu_out, zero, mem_rdata
  );
endinterface

// File: rtl/alu_ctrl.sv
// Multi-cycle instruction sequencer: fetches from a 16-word memory, drives the
// external registered ALU and executes LOAD/STORE/JMP/JZ/HALT control ops.
module alu_ctrl (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  alu_ctrl_if.master        bus,
  output logic              busy,
  output logic              halted,
  output logic [3:0]        pc
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPRD, S_OPWT, S_EXEC, S_WB, S_STORE, S_HALT
  } state_t;

  localparam logic [2:0] C_LOAD  = 3'b000;
  localparam logic [2:0] C_STORE = 3'b001;
  localparam logic [2:0] C_JMP   = 3'b010;
  localparam logic [2:0] C_JZ    = 3'b011;
  localparam logic [2:0] C_HALT  = 3'b100;

  state_t      state, state_nxt;
  logic [7:0]  ir;
  logic [7:0]  acc;
  logic [7:0]  data;
  logic [2:0]  opcode;
  logic        zflag;

  logic        dec_ctrl;
  logic [2:0]  dec_op;
  logic        jump_taken;

  // Decode works on the word arriving this cycle, before it lands in ir.
  assign dec_ctrl   = bus.mem_rdata[7];
  assign dec_op     = bus.mem_rdata[6:4];
  assign jump_taken = dec_ctrl && ((dec_op == C_JMP) || ((dec_op == C_JZ) && zflag));

  assign bus.opcode    = opcode;
  assign bus.accum     = acc;
  assign bus.data      = data;
  assign bus.mem_wdata = acc;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_HALT: if (start) state_nxt = S_FETCH;
      S_FETCH:        state_nxt = S_DECODE;
      S_DECODE: begin
        if (!dec_ctrl || dec_op == C_LOAD) state_nxt = S_OPRD;
        else if (dec_op == C_STORE)        state_nxt = S_STORE;
        else if (dec_op == C_HALT)         state_nxt = S_HALT;
        else                               state_nxt = S_FETCH;
      end
      S_OPRD:         state_nxt = S_OPWT;
      S_OPWT:         state_nxt = ir[7] ? S_FETCH : S_EXEC;
      S_EXEC:         state_nxt = S_WB;
      S_WB:           state_nxt = S_FETCH;
      S_STORE:        state_nxt = S_FETCH;
      default:        state_nxt = S_IDLE;
    endcase
  end

  // Strobes and address are pure functions of state so they never glitch across ops.
  always_comb begin
    busy         = 1'b1;
    halted       = 1'b0;
    bus.mem_rd   = 1'b0;
    bus.mem_wr   = 1'b0;
    bus.mem_addr = 4'd0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      S_FETCH: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = pc;
      end
      S_OPRD: begin
        bus.mem_rd   = 1'b1;
        bus.mem_addr = ir[3:0];
      end
      S_STORE: begin
        bus.mem_wr   = 1'b1;
        bus.mem_addr = ir[3:0];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= 4'd0;
      ir     <= 8'd0;
      acc    <= 8'd0;
      data   <= 8'd0;
      opcode <= 3'd0;
      zflag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT: if (start) pc <= 4'd0;
        S_DECODE: begin
          ir     <= bus.mem_rdata;
          opcode <= bus.mem_rdata[6:4];
          pc     <= jump_taken ? bus.mem_rdata[3:0] : pc + 4'd1;
        end
        S_OPWT: begin
          if (ir[7]) begin
            acc   <= bus.mem_rdata;
            zflag <= (bus.mem_rdata == 8'd0);
          end else begin
            data  <= bus.mem_rdata;
          end
        end
        S_WB: begin
          acc   <= bus.alu_out;
          zflag <= bus.zero;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed bench for alu_ctrl with a behavioural 16-word memory and registered ALU.
module tb_alu_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       halted;
  logic [3:0] pc;

  alu_ctrl_if bus ();

  alu_ctrl dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .bus    (bus.master),
    .busy   (busy),
    .halted (halted),
    .pc     (pc)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [16];
  int         wcnt [16] = '{default: 0};

  // Synchronous memory: read data appears the cycle after mem_rd.
  always @(posedge clk) begin
    if (bus.mem_rd) bus.mem_rdata <= mem[bus.mem_addr];
    if (bus.mem_wr) begin
      mem[bus.mem_addr]  <= bus.mem_wdata;
      wcnt[bus.mem_addr] <= wcnt[bus.mem_addr] + 1;
    end
  end

  function automatic logic [7:0] alu_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] d);
    case (op)
      3'b001:  return a + d;
      3'b010:  return a - d;
      3'b011:  return a & d;
      3'b100:  return a ^ d;
      3'b110:  return d;
      default: return a;
    endcase
  endfunction

  // Registered ALU: result is valid the cycle after operands are presented.
  always @(posedge clk) begin
    bus.alu_out <= alu_f(bus.opcode, bus.accum, bus.data);
    bus.zero    <= (alu_f(bus.opcode, bus.accum, bus.data) == 8'd0);
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_halt(input int bound, input string tag);
    for (int k = 0; k < bound && !halted; k++) @(negedge clk);
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic load_basic();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h88; mem[1] = 8'h19; mem[2] = 8'h9A; mem[3] = 8'hC0;
    mem[8] = 8'h05; mem[9] = 8'h03;
  endtask

  task automatic load_jz();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0] = 8'h88; mem[1] = 8'h28; mem[2] = 8'hB5; mem[3] = 8'h99;
    mem[4] = 8'hC0; mem[5] = 8'h9A; mem[6] = 8'hC0; mem[8] = 8'h42;
  endtask

  int         busy_cnt;
  int         halted_at;
  int         w9, w10;
  int         nfetch;
  logic [3:0] fetch_addr [4];
  logic [3:0] exp_fetch [4] = '{4'd0, 4'd15, 4'd0, 4'd15};

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    reset = 1'b1;
    start = 1'b1;

    // Reset held two cycles with start high
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy",   {31'd0, busy},   32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_pc",     {28'd0, pc},     32'd0);
    chk("rst_accum",  {24'd0, bus.accum}, 32'd0);
    chk("rst_data",   {24'd0, bus.data},  32'd0);
    chk("rst_opcode", {29'd0, bus.opcode}, 32'd0);
    chk("rst_rd",     {31'd0, bus.mem_rd}, 32'd0);
    chk("rst_wr",     {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_addr",   {28'd0, bus.mem_addr}, 32'd0);
    chk("rst_wdata",  {24'd0, bus.mem_wdata}, 32'd0);
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_no_fetch", {31'd0, busy}, 32'd0);

    // Basic program: LOAD 8, ADD 9, STORE 10, HALT
    load_basic();
    w10 = wcnt[10];
    @(negedge clk);
    start = 1'b1;
    busy_cnt  = 0;
    halted_at = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start = 1'b0;
        chk("first_fetch_rd", {31'd0, bus.mem_rd}, 32'd1);
      end
      if (busy) busy_cnt++;
      if (halted && halted_at == 0) halted_at = k;
    end
    chk("basic_busy_cycles", busy_cnt, 32'd15);
    chk("basic_halt_cycle",  halted_at, 32'd16);
    chk("basic_mem10",  {24'd0, mem[10]}, 32'h08);
    chk("basic_accum",  {24'd0, bus.accum}, 32'h08);
    chk("basic_wr10",   wcnt[10] - w10, 32'd1);

    // Restart from HALT: acc retained until the LOAD completes
    mem[10] = 8'h00;
    pulse_start();
    chk("rs_pc0",    {28'd0, pc}, 32'd0);
    chk("rs_busy",   {31'd0, busy}, 32'd1);
    chk("rs_halted", {31'd0, halted}, 32'd0);
    chk("rs_acc_kept", {24'd0, bus.accum}, 32'h08);
    repeat (3) @(negedge clk);
    chk("rs_acc_opwt", {24'd0, bus.accum}, 32'h08);
    @(negedge clk);
    chk("rs_acc_load", {24'd0, bus.accum}, 32'h05);
    wait_halt(40, "rs_halt");
    chk("rs_mem10", {24'd0, mem[10]}, 32'h08);

    // JZ taken after SUB yields zero
    do_reset();
    load_jz();
    mem[10] = 8'hFF;
    w9  = wcnt[9];
    w10 = wcnt[10];
    pulse_start();
    wait_halt(60, "jz_halt");
    chk("jz_mem10",  {24'd0, mem[10]}, 32'h00);
    chk("jz_wr10",   wcnt[10] - w10, 32'd1);
    chk("jz_no_wr9", wcnt[9] - w9, 32'd0);
    chk("jz_accum",  {24'd0, bus.accum}, 32'h00);

    // JZ not taken: ADD gives 0x84
    do_reset();
    load_jz();
    mem[1]  = 8'h18;
    mem[9]  = 8'h00;
    mem[10] = 8'h55;
    w10 = wcnt[10];
    pulse_start();
    wait_halt(60, "jzn_halt");
    chk("jzn_mem9",   {24'd0, mem[9]}, 32'h84);
    chk("jzn_no_wr10", wcnt[10] - w10, 32'd0);
    chk("jzn_accum",  {24'd0, bus.accum}, 32'h84);

    // PC wrap: JMP 15, NOP at 15 increments pc to 0
    do_reset();
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    mem[0]  = 8'hAF;
    mem[15] = 8'hF0;
    nfetch = 0;
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 20 && nfetch < 4; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (bus.mem_rd) begin
        fetch_addr[nfetch] = bus.mem_addr;
        nfetch++;
      end
    end
    chk("wrap_nfetch", nfetch, 32'd4);
    for (int i = 0; i < 4; i++) chk($sformatf("wrap_fetch%0d", i), {28'd0, fetch_addr[i]}, {28'd0, exp_fetch[i]});

    // Reset during EXEC of the ADD
    do_reset();
    chk("wrap_stop_busy", {31'd0, busy}, 32'd0);
    load_basic();
    @(negedge clk);
    start = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("exec_opcode", {29'd0, bus.opcode}, 32'd1);
    chk("exec_accum",  {24'd0, bus.accum}, 32'h05);
    chk("exec_data",   {24'd0, bus.data},  32'h03);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_busy",  {31'd0, busy}, 32'd0);
    chk("mid_accum", {24'd0, bus.accum}, 32'd0);
    chk("mid_wr",    {31'd0, bus.mem_wr}, 32'd0);
    chk("mid_pc",    {28'd0, pc}, 32'd0);
    pulse_start();
    wait_halt(40, "mid_halt");
    chk("mid_mem10", {24'd0, mem[10]}, 32'h08);
    chk("mid_accum_final", {24'd0, bus.accum}, 32'h08);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
